// File: rtl/ccc_pkg.sv
// Shared definitions for the 4x4 Colour Cell Compression encoder and decoder:
// block geometry, field offsets, luma weights and the encoder state type.
package ccc_pkg;

    localparam int BITS_PER_PIXEL = 24;
    localparam int BITS_PER_BLOCK = 64;

    localparam int BITMAP_LSB = 48;
    localparam int B0_LSB     = 24;
    localparam int B0_R_LSB   = 40;
    localparam int B0_G_LSB   = 32;
    localparam int B0_B_LSB   = 24;
    localparam int B1_LSB     = 0;
    localparam int B1_R_LSB   = 16;
    localparam int B1_G_LSB   = 8;
    localparam int B1_B_LSB   = 0;

    localparam int LUMA_CR = 77;
    localparam int LUMA_CG = 150;
    localparam int LUMA_CB = 29;

    typedef enum logic [2:0] {
        IDLE,
        LUMA,
        CLASSIFY,
        DIVIDE,
        FINISH
    } enc_state_t;

    // Weights sum to 256, so the weighted sum of an 8-bit pixel never exceeds 16 bits.
    function automatic logic [7:0] luma(input logic [23:0] p);
        logic [16:0] acc;
        acc = 17'(LUMA_CR) * 17'(p[23:16])
            + 17'(LUMA_CG) * 17'(p[15:8])
            + 17'(LUMA_CB) * 17'(p[7:0]);
        return acc[15:8];
    endfunction

endpackage

// File: rtl/ccc_div12.sv
// 12-bit by 5-bit restoring divider: one load cycle then 12 iterations,
// done pulses in the cycle the quotient becomes valid.
module ccc_div12 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] dividend,
    input  logic [4:0]  divisor,
    output logic [7:0]  quotient,
    output logic        done
);

    logic [11:0] q;
    logic [4:0]  rem;
    logic [4:0]  dvs;
    logic [3:0]  cnt;
    logic [5:0]  trial;

    // Remainder stays below the divisor, so one extra bit holds the shifted trial value.
    assign trial    = {rem, q[11]};
    assign quotient = q[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            rem  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q   <= dividend;
                rem <= '0;
                dvs <= divisor;
                cnt <= 4'd12;
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
                if (trial >= {1'b0, dvs}) begin
                    rem <= 5'(trial - {1'b0, dvs});
                    q   <= {q[10:0], 1'b1};
                end else begin
                    rem <= trial[4:0];
                    q   <= {q[10:0], 1'b0};
                end
                if (cnt == 4'd1) done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccc_encoder_4x4.sv
// Encodes one 4x4 RGB888 tile into a 64-bit CCC block (bucket bitmap plus two
// rounded bucket averages) with a fixed 111-cycle start-to-done latency.
module ccc_encoder_4x4
    import ccc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [383:0] rgb_data,
    input  logic         start,
    output logic         busy,
    output logic [63:0]  ccc_data,
    output logic         done
);

    enc_state_t state, state_nx;

    logic [383:0] tile;
    logic [3:0]   idx;      // pixel index in LUMA/CLASSIFY, iteration step in DIVIDE
    logic [2:0]   div_idx;
    logic [2:0]   res_idx;
    logic [11:0]  lsum;
    logic [15:0]  bitmap;
    logic [11:0]  sum_r [2];
    logic [11:0]  sum_g [2];
    logic [11:0]  sum_b [2];
    logic [4:0]   cnt   [2];
    logic [7:0]   avg   [6];

    logic [8:0]   pix_base;
    logic [23:0]  pix;
    logic [7:0]   y;
    logic         cls_bit;
    logic         bkt;
    logic [11:0]  div_sum;
    logic         div_start;
    logic         div_done;
    logic [11:0]  div_dividend;
    logic [4:0]   div_divisor;
    logic [7:0]   div_q;
    logic [23:0]  b0, b1;
    logic [63:0]  blk_nx;

    assign pix_base = 9'(idx) * 9'(BITS_PER_PIXEL);
    assign pix      = tile[pix_base +: BITS_PER_PIXEL];
    assign y        = luma(pix);
    assign cls_bit  = ({y, 4'b0000} >= lsum);
    assign busy     = (state != IDLE) || done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = LUMA;
            LUMA:     if (idx == 4'd15) state_nx = CLASSIFY;
            CLASSIFY: if (idx == 4'd15) state_nx = DIVIDE;
            DIVIDE:   if (idx == 4'd12 && div_idx == 3'd5) state_nx = FINISH;
            FINISH:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Division order b0R, b0G, b0B, b1R, b1G, b1B; rounding bias folded into the dividend.
    always_comb begin
        bkt = (div_idx >= 3'd3);
        case (div_idx)
            3'd0, 3'd3: div_sum = sum_r[bkt];
            3'd1, 3'd4: div_sum = sum_g[bkt];
            default:    div_sum = sum_b[bkt];
        endcase
        div_divisor  = cnt[bkt];
        div_dividend = div_sum + 12'(cnt[bkt] >> 1);
        div_start    = (state == DIVIDE) && (idx == 4'd0);
    end

    ccc_div12 u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_q),
        .done     (div_done)
    );

    // The last quotient is still in the divider during FINISH, so b1_B comes from it directly.
    always_comb begin
        b1     = {avg[3], avg[4], div_q};
        b0     = (cnt[0] == 5'd0) ? b1 : {avg[0], avg[1], avg[2]};
        blk_nx = '0;
        blk_nx[BITMAP_LSB +: 16] = bitmap;
        blk_nx[B0_LSB +: 24]     = b0;
        blk_nx[B1_LSB +: 24]     = b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile     <= '0;
            idx      <= '0;
            div_idx  <= '0;
            res_idx  <= '0;
            lsum     <= '0;
            bitmap   <= '0;
            ccc_data <= '0;
            done     <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                sum_r[k] <= '0;
                sum_g[k] <= '0;
                sum_b[k] <= '0;
                cnt[k]   <= '0;
            end
            for (int k = 0; k < 6; k++) avg[k] <= '0;
        end else begin
            done <= 1'b0;
            if (div_done) begin
                avg[res_idx] <= div_q;
                res_idx      <= res_idx + 3'd1;
            end
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (start) begin
                        tile    <= rgb_data;
                        lsum    <= '0;
                        bitmap  <= '0;
                        div_idx <= '0;
                        res_idx <= '0;
                        for (int k = 0; k < 2; k++) begin
                            sum_r[k] <= '0;
                            sum_g[k] <= '0;
                            sum_b[k] <= '0;
                            cnt[k]   <= '0;
                        end
                    end
                end
                LUMA: begin
                    lsum <= lsum + 12'(y);
                    idx  <= idx + 4'd1;
                end
                CLASSIFY: begin
                    bitmap[idx]    <= cls_bit;
                    sum_r[cls_bit] <= sum_r[cls_bit] + 12'(pix[23:16]);
                    sum_g[cls_bit] <= sum_g[cls_bit] + 12'(pix[15:8]);
                    sum_b[cls_bit] <= sum_b[cls_bit] + 12'(pix[7:0]);
                    cnt[cls_bit]   <= cnt[cls_bit] + 5'd1;
                    idx            <= idx + 4'd1;
                end
                DIVIDE: begin
                    if (idx == 4'd12) begin
                        idx     <= '0;
                        div_idx <= div_idx + 3'd1;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                FINISH: begin
                    ccc_data <= blk_nx;
                    done     <= 1'b1;
                end
                default: idx <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ccc_encoder_4x4.sv
// Bench for ccc_encoder_4x4: directed and random tiles compared against an
// arithmetic reference of the CCC encoding, plus latency, handshake and reset checks.
module tb_ccc_encoder_4x4;

    logic         clk;
    logic         rst_n;
    logic [383:0] rgb_data;
    logic         start;
    logic         busy;
    logic [63:0]  ccc_data;
    logic         done;

    int checks;
    int failures;

    ccc_encoder_4x4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rgb_data (rgb_data),
        .start    (start),
        .busy     (busy),
        .ccc_data (ccc_data),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [383:0] t);
        int px[16][3];
        int yv[16];
        int lsum;
        int sums[2][3];
        int cnts[2];
        int avgs[2][3];
        logic [15:0] bm;
        lsum = 0;
        bm = '0;
        for (int b = 0; b < 2; b++) begin
            cnts[b] = 0;
            for (int c = 0; c < 3; c++) sums[b][c] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            px[i][0] = int'(t[i*24+16 +: 8]);
            px[i][1] = int'(t[i*24+8 +: 8]);
            px[i][2] = int'(t[i*24 +: 8]);
            yv[i] = (77 * px[i][0] + 150 * px[i][1] + 29 * px[i][2]) / 256;
            lsum += yv[i];
        end
        for (int i = 0; i < 16; i++) begin
            int k;
            k = (yv[i] * 16 >= lsum) ? 1 : 0;
            bm[i] = (k == 1);
            cnts[k]++;
            for (int c = 0; c < 3; c++) sums[k][c] += px[i][c];
        end
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 3; c++)
                avgs[b][c] = (cnts[b] == 0) ? 0 : (sums[b][c] + cnts[b] / 2) / cnts[b];
        if (cnts[0] == 0)
            for (int c = 0; c < 3; c++) avgs[0][c] = avgs[1][c];
        return {bm, 8'(avgs[0][0]), 8'(avgs[0][1]), 8'(avgs[0][2]),
                8'(avgs[1][0]), 8'(avgs[1][1]), 8'(avgs[1][2])};
    endfunction

    function automatic logic [383:0] fill(input logic [23:0] col);
        logic [383:0] t;
        for (int i = 0; i < 16; i++) t[i*24 +: 24] = col;
        return t;
    endfunction

    function automatic logic [383:0] rand_tile();
        logic [383:0] t;
        for (int i = 0; i < 16; i++) t[i*24 +: 24] = 24'($urandom);
        return t;
    endfunction

    function automatic logic [383:0] two_level_tile();
        logic [383:0] t;
        logic [23:0] ca, cb;
        ca = 24'($urandom);
        cb = 24'($urandom);
        for (int i = 0; i < 16; i++) t[i*24 +: 24] = $urandom_range(0, 1) ? ca : cb;
        return t;
    endfunction

    // Drives one tile with a single-cycle start, scrambles rgb_data after the accept,
    // and measures latency and busy length up to done.
    task automatic encode(input logic [383:0] t, input string tag);
        int lat, bcnt;
        @(negedge clk);
        rgb_data = t;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rgb_data = rand_tile();
        bcnt = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd111);
        check({tag, "_busy_len"}, 64'(bcnt), 64'd112);
        check({tag, "_data"}, ccc_data, model(t));
        @(posedge clk);
        #1;
        check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        logic [383:0] t, ta, tb, tc;
        int lat, ndone;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        rgb_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {ccc_data, 6'd0, busy, done}, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;

        encode(fill(24'h102030), "uniform");
        check("uniform_const", ccc_data, 64'hFFFF_102030_102030);

        t = fill(24'h000000);
        for (int i = 8; i < 16; i++) t[i*24 +: 24] = 24'hFFFFFF;
        encode(t, "half");
        check("half_const", ccc_data, 64'hFF00_000000_FFFFFF);

        t = fill(24'h000000);
        t[5*24 +: 24] = 24'hFFFFFF;
        encode(t, "single");
        check("single_const", ccc_data, 64'h0020_000000_FFFFFF);

        t = fill(24'h000000);
        t[1*24 +: 24] = 24'hFF0000;
        t[2*24 +: 24] = 24'hFE0000;
        encode(t, "round");
        check("round_const", ccc_data, 64'h0006_000000_FF0000);

        encode(fill(24'h000000), "black");
        check("black_const", ccc_data, 64'hFFFF_000000_000000);

        for (int n = 0; n < 5; n++) encode(rand_tile(), $sformatf("rand%0d", n));
        for (int n = 0; n < 4; n++) encode(two_level_tile(), $sformatf("twolvl%0d", n));

        // start held high: the tile present at each IDLE accept is the one encoded
        ta = rand_tile();
        tb = two_level_tile();
        tc = rand_tile();
        @(negedge clk);
        rgb_data = ta;
        start = 1'b1;
        @(posedge clk);
        #1;
        rgb_data = tb;
        wait_done(lat);
        check("hold_lat_a", 64'(lat), 64'd111);
        check("hold_data_a", ccc_data, model(ta));
        @(posedge clk);
        #1;
        rgb_data = tc;
        check("hold_done_pulse", {63'd0, done}, 64'd0);
        wait_done(lat);
        check("hold_lat_b", 64'(lat), 64'd111);
        check("hold_data_b", ccc_data, model(tb));
        start = 1'b0;
        @(posedge clk);
        #1;
        check("hold_idle", {62'd0, busy, done}, 64'd0);

        // reset in the middle of an encode
        @(negedge clk);
        rgb_data = rand_tile();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midreset_state", {ccc_data, 6'd0, busy, done}, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midreset_no_done", 64'(ndone), 64'd0);
        check("midreset_data_kept", ccc_data, 64'd0);
        encode(two_level_tile(), "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ccc_encoder_4x4.md
# ccc_encoder_4x4

Colour Cell Compression encoder for one 4x4 RGB888 tile. It takes 16 pixels and produces one 64-bit CCC block: a 16-bit bucket bitmap plus two RGB888 bucket averages. The block format is exactly the one consumed by the 4x4 CCC decoder in the same codec IP. It sits at the ingest side of the codec, one instance per tile lane, and is driven by a start/done handshake like the decoder.

## Interface
Parameters:
- none. All widths come from `ccc_pkg`.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rgb_data`  in  384  16 pixels; pixel i = y*4+x occupies bits [i*24 +: 24], packed {R[23:16], G[15:8], B[7:0]}.
- `start`  in  1  request to encode; sampled only in IDLE.
- `busy`  out  1  high from the start-accept edge until `done`, inclusive of the done cycle.
- `ccc_data`  out  64  {bitmap[63:48], b0_R[47:40], b0_G[39:32], b0_B[31:24], b1_R[23:16], b1_G[15:8], b1_B[7:0]}.
- `done`  out  1  one-cycle pulse; `ccc_data` is valid from this cycle onward.

## Operation
- Reset values: `ccc_data`=0, `done`=0, `busy`=0, state=IDLE, all accumulators 0.
- **IDLE**
  - With `start`=1: latch `rgb_data` into an internal tile register, clear the accumulators, go to LUMA.
  - `start` asserted outside IDLE is ignored. It is neither queued nor does it restart the encode.
- **LUMA** (16 cycles, pixel index 0..15):
  - Y_i = (77*R + 150*G + 29*B) >> 8, giving an 8-bit result.
  - lsum += Y_i. `lsum` is 12 bits; maximum 4080.
- **CLASSIFY** (16 cycles, index 0..15):
  - bit_i = (Y_i*16 >= lsum). This compares against the mean without a division.
  - Y_i is recomputed from the tile register, not stored.
  - bit_i=1 adds the pixel to bucket1; 0 adds it to bucket0.
  - Per bucket: 12-bit sums for R, G and B, and a 5-bit count.
- **DIVIDE** (6 sequential divisions, order b0R, b0G, b0B, b1R, b1G, b1B):
  - avg = (sum + (count>>1)) / count, i.e. rounded to nearest; the result is 8 bits.
  - bucket1 count is always >= 1, because the max-luma pixel always satisfies the compare.
  - bucket0 count 0 (all Y equal): skip the b0 divisions and use b0 = b1 averages. The cycle count does not change; the divider still runs and its result is discarded.
- **FINISH** (1 cycle):
  - Load `ccc_data` and pulse `done`.
  - Return to IDLE.
- `ccc_data` holds its value until the next FINISH. It is not cleared in IDLE.
- Reset asserted mid-encode: immediate return to IDLE. All reset values apply and no `done` is produced.

## Timing
- The start-accept edge is E0.
- LUMA occupies cycles E0+1..E0+16.
- CLASSIFY occupies E0+17..E0+32.
- DIVIDE occupies E0+33..E0+110: 6 x 13 cycles, each 1 load plus 12 restoring iterations.
- `done`=1 and the new `ccc_data` appear after edge E0+111. Latency is fixed at 111 cycles, independent of data.
- Earliest next accept: the IDLE cycle following `done`. Back-to-back throughput is 1 tile per 112 cycles.
- `rgb_data` may change after E0; it is not observed again.

## Structure
- `ccc_pkg` holds:
  - `BITS_PER_PIXEL`=24 and `BITS_PER_BLOCK`=64;
  - the `ccc_data` field offsets;
  - the luma coefficients 77/150/29;
  - the encoder state enum {IDLE, LUMA, CLASSIFY, DIVIDE, FINISH}.
- The decoder shares this package.
- One sub-module, `ccc_div12`: a 12-bit by 5-bit sequential restoring divider.
  - Interface: `start`, `dividend`, `divisor`, `quotient[7:0]`, `done`.
  - 13-cycle fixed latency; same `clk`/`rst_n`.

## Test plan
- Uniform tile, all pixels 0x102030 -> `ccc_data`=0xFFFF_102030_102030; `done` exactly 111 cycles after accept; `busy` high for 112 cycles.
- Pixels 0..7 = 0x000000, pixels 8..15 = 0xFFFFFF -> `ccc_data`=0xFF00_000000_FFFFFF.
- Pixel 5 = 0xFFFFFF, all others 0x000000 -> bitmap 0x0020, b0=0x000000, b1=0xFFFFFF.
- Rounding case, with pixels 1 and 2 in bucket1:
  - stimulus: pixels 0 and 3..15 = 0x000000; pixel 1 = 0xFF0000; pixel 2 = 0xFE0000;
  - response: bitmap 0x0006, b1_R = (255+254+1)/2 = 0xFF, b1 G/B = 0, b0 = 0x000000.
- Protocol robustness: `start` held high through the whole encode gives exactly one `done` per 112 cycles; the next tile is latched only in the IDLE cycle after `done`.
- Reset robustness: `rst_n` pulsed low at E0+50 gives `ccc_data`=0 and no `done`. A new start afterwards encodes correctly.
